// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple-carry adder.
// Consumers import this package to size operands and to carry {cout, sum} results around.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

    // Full-width result as consumers see it; narrower instances zero-extend sum.
    typedef struct packed {
        logic                    cout;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

    function automatic bit fa_width_legal(input int width);
        return (width >= 1) && (width <= FA_MAX_WIDTH);
    endfunction

    function automatic fa_result_t fa_pack_result(input logic cout,
                                                  input logic [FA_MAX_WIDTH-1:0] sum);
        fa_result_t r;
        r.cout = cout;
        r.sum  = sum;
        return r;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder; one link of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle latency.
// Optional registered signed-overflow output ovf when FULL_ADDER_OVERFLOW_EN is defined.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef FULL_ADDER_OVERFLOW_EN
    output logic             out_valid,
    output logic             ovf
`else
    output logic             out_valid
`endif
);

    generate
        if (!fa_width_legal(WIDTH)) begin : g_bad_width
            $error("full_adder: WIDTH out of range 1..64");
        end
    endgenerate

    // carry[i] is the carry into bit i; carry[0] = cin, carry[WIDTH] = cout.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_adder_cell u_cell (
                .a  (a[i]),
                .b  (b[i]),
                .ci (carry[i]),
                .s  (sum_comb[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the datapath registers are reset too because
    // sum/cout are architecturally visible after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Load only on valid so idle-cycle X on operands never reaches the outputs.
            if (in_valid) begin
                sum  <= sum_comb;
                cout <= carry[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVERFLOW_EN
    // For WIDTH=1 carry[WIDTH-1] is carry[0] = cin, as intended.
    logic ovf_comb;
    assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_comb;
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH=1 and WIDTH=8.
// Checks ovf as well when FULL_ADDER_OVERFLOW_EN is defined.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       v1, a1, b1, cin1;
    logic       sum1, cout1, ov1;
    logic       v8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       cout8, ov8;
`ifdef FULL_ADDER_OVERFLOW_EN
    logic       ovf1, ovf8;
`endif

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sum       (sum1),
        .cout      (cout1),
`ifdef FULL_ADDER_OVERFLOW_EN
        .out_valid (ov1),
        .ovf       (ovf1)
`else
        .out_valid (ov1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sum       (sum8),
        .cout      (cout8),
`ifdef FULL_ADDER_OVERFLOW_EN
        .out_valid (ov8),
        .ovf       (ovf8)
`else
        .out_valid (ov8)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle 1ns past it for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        v1 = v; a1 = a; b1 = b; cin1 = c;
        step();
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        v8 = v; a8 = a; b8 = b; cin8 = c;
        step();
    endtask

    task automatic check8(input string tag, input logic [7:0] s, input logic co,
                          input logic ov, input logic vf);
        check({tag, ".sum"},  {8'h0, sum8},  {8'h0, s});
        check({tag, ".cout"}, {15'h0, cout8}, {15'h0, co});
        check({tag, ".vld"},  {15'h0, ov8},   {15'h0, vf});
`ifdef FULL_ADDER_OVERFLOW_EN
        check({tag, ".ovf"},  {15'h0, ovf8},  {15'h0, ov});
`else
        if (ov === 1'bz) $display("unreachable");
`endif
    endtask

    // Exhaustive WIDTH=1 table: vec = {a, b, cin}, exp = {cout, sum}, eovf = signed overflow.
    logic [2:0] vec  [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    logic [1:0] exp1 [8] = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b01,  2'b10,  2'b10,  2'b11};
    logic       eovf [8] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0};

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        v8 = 1'b0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0;
        step();
        step();
        check("rst.sum1",  {15'h0, sum1},  16'h0);
        check("rst.cout1", {15'h0, cout1}, 16'h0);
        check("rst.vld1",  {15'h0, ov1},   16'h0);
        check8("rst.w8", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // WIDTH=1 exhaustive, back-to-back valid.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] t;
            t = vec[i];
            drive1(1'b1, t[2], t[1], t[0]);
            check($sformatf("w1.vec%0d", i), {14'h0, cout1, sum1}, {14'h0, exp1[i]});
            check($sformatf("w1.vld%0d", i), {15'h0, ov1}, 16'h1);
`ifdef FULL_ADDER_OVERFLOW_EN
            check($sformatf("w1.ovf%0d", i), {15'h0, ovf1}, {15'h0, eovf[i]});
`endif
        end

        // Reset wins over a valid operand presented at the same edge.
        rst = 1'b1;
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        check("w1.rst.cs",  {14'h0, cout1, sum1}, 16'h0);
        check("w1.rst.vld", {15'h0, ov1},         16'h0);
        rst = 1'b0;
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        check("w1.post.cs",  {14'h0, cout1, sum1}, 16'h3);
        check("w1.post.vld", {15'h0, ov1},         16'h1);

        // Hold: outputs keep 1+0+0 while idle operands change.
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        check("w1.hold0.cs", {14'h0, cout1, sum1}, 16'h1);
        for (int k = 0; k < 3; k++) begin
            drive1(1'b0, 1'b1, 1'b1, (k == 2) ? 1'bx : 1'b1);
            check($sformatf("w1.hold%0d.cs", k + 1),  {14'h0, cout1, sum1}, 16'h1);
            check($sformatf("w1.hold%0d.vld", k + 1), {15'h0, ov1},         16'h0);
        end

        // WIDTH=8 boundaries.
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1); check8("w8.ones",  8'hFF, 1'b1, 1'b0, 1'b1);
        drive8(1'b1, 8'h00, 8'h00, 1'b0); check8("w8.zero",  8'h00, 1'b0, 1'b0, 1'b1);
        drive8(1'b1, 8'h80, 8'h80, 1'b0); check8("w8.negov", 8'h00, 1'b1, 1'b1, 1'b1);
        drive8(1'b1, 8'h7F, 8'h01, 1'b0); check8("w8.posov", 8'h80, 1'b0, 1'b1, 1'b1);

        // Back-to-back.
        drive8(1'b1, 8'h12, 8'h34, 1'b0); check8("w8.b2b0", 8'h46, 1'b0, 1'b0, 1'b1);
        drive8(1'b1, 8'hF0, 8'h10, 1'b1); check8("w8.b2b1", 8'h01, 1'b1, 1'b0, 1'b1);

        // Idle cycle holds the last result.
        drive8(1'b0, 8'hAA, 8'h55, 1'b1); check8("w8.hold", 8'h01, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream drops exactly the operand of the reset cycle.
        drive8(1'b1, 8'h01, 8'h01, 1'b0); check8("w8.ms0", 8'h02, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        drive8(1'b1, 8'h03, 8'h03, 1'b0); check8("w8.ms1", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive8(1'b1, 8'h05, 8'h05, 1'b0); check8("w8.ms2", 8'h0A, 1'b0, 1'b0, 1'b1);
        drive8(1'b1, 8'h10, 8'h20, 1'b1); check8("w8.ms3", 8'h31, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
